// File: rtl/arm_sync_reg_file.sv
// Synchronous ARM CS5 register file: strobe synchronisers, byte-masked write commit on
// write-strobe trailing edge, registered reads, ID/CTRL/IRQ/CYCLES registers and scratch space.
module arm_sync_reg_file #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned IRQ_W    = 8,
  parameter logic [31:0] ID_VALUE = 32'h4543_0453
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  input  logic [3:0]        be,
  input  logic              as,
  input  logic              ws_n,
  input  logic              rs_n,
  input  logic [IRQ_W-1:0]  irq_in,
  output logic [31:0]       data_out,
  output logic              rd_active,
  output logic              irq,
  output logic [7:0]        led_out
);

  localparam int unsigned IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SYNC_W   = 3;
  localparam int unsigned FIRST_SC = 5;

  localparam logic [IDX_W-1:0]  IDX_ID     = IDX_W'(0);
  localparam logic [IDX_W-1:0]  IDX_CTRL   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_STAT   = IDX_W'(2);
  localparam logic [IDX_W-1:0]  IDX_MASK   = IDX_W'(3);
  localparam logic [IDX_W-1:0]  IDX_CYCLES = IDX_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

  // Synchroniser chains; index 0 is s1
  logic [SYNC_W-1:0] ws_sync;
  logic [SYNC_W-1:0] rs_sync;
  logic [1:0]        as_sync;
  logic [IRQ_W-1:0]  irq_s1;
  logic [IRQ_W-1:0]  irq_s2;
  logic [IRQ_W-1:0]  irq_s3;

  // Arming: a strobe must be seen genuinely high after reset before its edges count
  logic              sync_live;
  logic              ws_armed;
  logic              rs_armed;
  logic              wr_open;

  // Write holding registers
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_ok;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        wr_be;

  // Read address capture
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_ok;

  // Register file state
  logic [DATA_W-1:0] ctrl;
  logic [IRQ_W-1:0]  irq_status;
  logic [IRQ_W-1:0]  irq_mask;
  logic [DATA_W-1:0] cycles;
  logic [DATA_W-1:0] scratch [FIRST_SC:NUM_REGS-1];

  // Combinational decode
  logic              in_range_c;
  logic [IDX_W-1:0]  addr_idx_c;
  logic              commit_c;
  logic              rd_fire_c;
  logic [DATA_W-1:0] wmask_c;
  logic [IRQ_W-1:0]  irq_rise_c;
  logic [IRQ_W-1:0]  irq_clr_c;
  logic [DATA_W-1:0] rd_val_c;

  function automatic logic [DATA_W-1:0] byte_mask(input logic [3:0] ben);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{~ben[b]}};
    end
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_val,
                                              input logic [DATA_W-1:0] new_val,
                                              input logic [DATA_W-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign in_range_c = (address < ADDR_LIMIT);
  assign addr_idx_c = address[IDX_W+1:2];

  always_comb begin
    wmask_c    = byte_mask(wr_be);
    commit_c   = ws_sync[1] & ~ws_sync[2] & wr_open & wr_ok;
    rd_fire_c  = ~rs_sync[1] & rs_sync[2] & as_sync[1] & rs_armed;
    irq_rise_c = irq_s2 & ~irq_s3;
    irq_clr_c  = '0;
    if (commit_c && (wr_idx == IDX_STAT)) begin
      irq_clr_c = wr_data[IRQ_W-1:0] & wmask_c[IRQ_W-1:0];
    end
  end

  // Read mux over current (pre-write) register contents
  always_comb begin
    rd_val_c = '0;
    if (rd_ok) begin
      case (rd_idx)
        IDX_ID:     rd_val_c = ID_VALUE;
        IDX_CTRL:   rd_val_c = ctrl;
        IDX_STAT:   rd_val_c = DATA_W'(irq_status);
        IDX_MASK:   rd_val_c = DATA_W'(irq_mask);
        IDX_CYCLES: rd_val_c = cycles;
        default: begin
          for (int unsigned i = FIRST_SC; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_val_c = scratch[i];
          end
        end
      endcase
    end
  end

  // Synchronisers and strobe arming
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ws_sync   <= '1;
      rs_sync   <= '1;
      as_sync   <= '0;
      irq_s1    <= '0;
      irq_s2    <= '0;
      irq_s3    <= '0;
      sync_live <= 1'b0;
      ws_armed  <= 1'b0;
      rs_armed  <= 1'b0;
      wr_open   <= 1'b0;
    end else begin
      ws_sync   <= {ws_sync[1:0], ws_n};
      rs_sync   <= {rs_sync[1:0], rs_n};
      as_sync   <= {as_sync[0], as};
      irq_s1    <= irq_in;
      irq_s2    <= irq_s1;
      irq_s3    <= irq_s2;
      sync_live <= 1'b1;
      ws_armed  <= ws_armed | (sync_live & ws_sync[0]);
      rs_armed  <= rs_armed | (sync_live & rs_sync[0]);
      if (commit_c) begin
        wr_open <= 1'b0;
      end else if (ws_armed && !ws_sync[0]) begin
        wr_open <= 1'b1;
      end
    end
  end

  // Bus capture into holding registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      wr_ok   <= 1'b0;
      wr_data <= '0;
      wr_be   <= '1;
      rd_idx  <= '0;
      rd_ok   <= 1'b0;
    end else begin
      if (!ws_sync[0] && as_sync[0]) begin
        wr_idx  <= addr_idx_c;
        wr_ok   <= in_range_c;
        wr_data <= data_in;
        wr_be   <= be;
      end
      if (!rs_sync[0] && as_sync[0]) begin
        rd_idx <= addr_idx_c;
        rd_ok  <= in_range_c;
      end
    end
  end

  // Register file updates; an irq edge beats a same-cycle W1C clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl       <= '0;
      irq_status <= '0;
      irq_mask   <= '0;
      cycles     <= '0;
      for (int unsigned i = FIRST_SC; i < NUM_REGS; i++) begin
        scratch[i] <= '0;
      end
    end else begin
      cycles     <= cycles + DATA_W'(1);
      irq_status <= (irq_status & ~irq_clr_c) | irq_rise_c;
      if (commit_c && (wr_idx == IDX_CTRL)) begin
        ctrl <= merge(ctrl, wr_data, wmask_c);
      end
      if (commit_c && (wr_idx == IDX_MASK)) begin
        irq_mask <= IRQ_W'(merge(DATA_W'(irq_mask), wr_data, wmask_c));
      end
      for (int unsigned i = FIRST_SC; i < NUM_REGS; i++) begin
        if (commit_c && (wr_idx == IDX_W'(i))) begin
          scratch[i] <= merge(scratch[i], wr_data, wmask_c);
        end
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out  <= '0;
      rd_active <= 1'b0;
      irq       <= 1'b0;
      led_out   <= '0;
    end else begin
      if (rd_fire_c) data_out <= rd_val_c;
      rd_active <= ~rs_sync[0] & as_sync[0];
      irq       <= |(irq_status & irq_mask);
      led_out   <= ctrl[7:0];
    end
  end

endmodule

// File: tb/tb_arm_sync_reg_file.sv
// Self-checking bench for arm_sync_reg_file: bus write/read tasks with a read-result scoreboard.
module tb_arm_sync_reg_file;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = 24;
  localparam int unsigned IRQ_W    = 8;
  localparam logic [31:0] ID_VALUE = 32'h4543_0453;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic [3:0]        be;
  logic              as;
  logic              ws_n;
  logic              rs_n;
  logic [IRQ_W-1:0]  irq_in;
  logic [31:0]       data_out;
  logic              rd_active;
  logic              irq;
  logic [7:0]        led_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q [$];

  arm_sync_reg_file #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .IRQ_W   (IRQ_W),
    .ID_VALUE(ID_VALUE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .data_in  (data_in),
    .be       (be),
    .as       (as),
    .ws_n     (ws_n),
    .rs_n     (rs_n),
    .irq_in   (irq_in),
    .data_out (data_out),
    .rd_active(rd_active),
    .irq      (irq),
    .led_out  (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic write_begin(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    address = a;
    data_in = d;
    be      = b;
    as      = 1'b1;
    ws_n    = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic write_end();
    ws_n = 1'b1;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] b);
    write_begin(a, d, b);
    write_end();
    repeat (3) @(negedge clk);
    as = 1'b0;
    be = 4'hF;
    repeat (2) @(negedge clk);
  endtask

  // Data sampled exactly two edges after the edge that first sees rs_n low
  task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] got);
    @(negedge clk);
    address = a;
    as      = 1'b1;
    rs_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = data_out;
    check("rd_active", {31'b0, rd_active}, 32'd1);
    @(negedge clk);
    rs_n = 1'b1;
    as   = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic read_expect(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    bus_read(a, got);
    check(tag, got, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c1;
    logic [31:0] c2;

    rst_n   = 1'b0;
    address = '0;
    data_in = '0;
    be      = 4'hF;
    as      = 1'b0;
    ws_n    = 1'b1;
    rs_n    = 1'b1;
    irq_in  = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("reset_data_out", data_out, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_led", {24'b0, led_out}, 32'h0);
    check("reset_rd_active", {31'b0, rd_active}, 32'h0);
    read_expect("id_read", 24'h00, ID_VALUE);
    read_expect("ctrl_reset", 24'h04, 32'h0);

    // Byte-masked writes to scratch word 5
    bus_write(24'h14, 32'hAABB_CCDD, 4'b0000);
    bus_write(24'h14, 32'h1122_3344, 4'b1010);
    read_expect("byte_mask", 24'h14, 32'hAA22_CC44);
    bus_write(24'h14, 32'h5555_5555, 4'b1111);
    read_expect("all_be_high", 24'h14, 32'hAA22_CC44);
    bus_write(24'h54, 32'h1234_5678, 4'b0000);
    read_expect("oob_write_alias", 24'h14, 32'hAA22_CC44);
    bus_write(24'h3C, 32'hCAFE_F00D, 4'b0000);
    read_expect("last_scratch", 24'h3C, 32'hCAFE_F00D);

    // LED update lands exactly three edges after ws_n is sampled high
    write_begin(24'h04, 32'h0000_00A5, 4'b0000);
    write_end();
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("led_k2_old", {24'b0, led_out}, 32'h0);
    @(posedge clk);
    #1;
    check("led_k3_new", {24'b0, led_out}, 32'hA5);
    @(negedge clk);
    as = 1'b0;
    repeat (3) @(negedge clk);

    // Read-only registers and out-of-range read
    bus_write(24'h00, 32'hFFFF_FFFF, 4'b0000);
    bus_write(24'h10, 32'hFFFF_FFFF, 4'b0000);
    read_expect("id_after_write", 24'h00, ID_VALUE);
    read_expect("oob_read", 24'(NUM_REGS * 4), 32'h0);
    bus_read(24'h10, c1);
    repeat (93) @(negedge clk);
    bus_read(24'h10, c2);
    check("cycles_delta", c2 - c1, 32'd100);

    // Mask upper bits read zero
    bus_write(24'h0C, 32'hFFFF_FFFF, 4'b0000);
    read_expect("mask_width", 24'h0C, 32'h0000_00FF);
    bus_write(24'h0C, 32'h0000_0005, 4'b0000);
    read_expect("mask_set", 24'h0C, 32'h0000_0005);

    // irq_in[0] edge reaches irq three edges after it is first sampled
    @(negedge clk);
    irq_in[0] = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("irq_k2_low", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("irq_k3_high", {31'b0, irq}, 32'h1);
    @(negedge clk);
    irq_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    read_expect("status_bit0", 24'h08, 32'h01);

    @(negedge clk);
    irq_in[1] = 1'b1;
    repeat (4) @(negedge clk);
    irq_in[1] = 1'b0;
    repeat (3) @(negedge clk);
    read_expect("status_bit01", 24'h08, 32'h03);
    check("irq_still_high", {31'b0, irq}, 32'h1);

    bus_write(24'h08, 32'h0000_0001, 4'b0000);
    read_expect("status_w1c", 24'h08, 32'h02);
    check("irq_cleared", {31'b0, irq}, 32'h0);

    // W1C of bit 2 coincides with an irq_in[2] edge; the set must win
    write_begin(24'h08, 32'h0000_0004, 4'b0000);
    irq_in[2] = 1'b1;
    write_end();
    repeat (5) @(negedge clk);
    as = 1'b0;
    check("set_wins_irq", {31'b0, irq}, 32'h1);
    read_expect("set_wins_status", 24'h08, 32'h06);
    irq_in[2] = 1'b0;

    // Reset during a write discards it; the stale low strobe must not commit
    write_begin(24'h18, 32'hDEAD_BEEF, 4'b0000);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    write_end();
    repeat (4) @(negedge clk);
    as = 1'b0;
    repeat (2) @(negedge clk);
    read_expect("reset_mid_write", 24'h18, 32'h0);
    read_expect("status_after_reset", 24'h08, 32'h0);
    check("led_after_reset", {24'b0, led_out}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
